// File: rtl/d_dram_arb_pkg.sv
// Shared definitions for the two-port data-RAM arbiter.
//   arb_state_e : arbiter FSM states (free arbitration / port-1 locked burst)
//   PORT_LSU    : index of the load/store port (port 0)
//   PORT_DMA    : index of the DMA port (port 1)
//   IDLE_LIMIT  : consecutive port-1 idle cycles that end a locked burst
package d_dram_arb_pkg;

  typedef enum logic {
    ARB_ST_ARB  = 1'b0,
    ARB_ST_LOCK = 1'b1
  } arb_state_e;

  localparam int PORT_LSU   = 0;
  localparam int PORT_DMA   = 1;
  localparam int IDLE_LIMIT = 2;

endpackage

// File: rtl/d_dram_arb_rr.sv
// Two-way round-robin picker.
//   eligible [1:0] : ports that may be granted this cycle
//   ptr            : port favoured when both are eligible
//   grant    [1:0] : one-hot grant (all zero when nothing is eligible)
module d_dram_arb_rr (
  input  logic [1:0] eligible,
  input  logic       ptr,
  output logic [1:0] grant
);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    grant = '0;
    if (&eligible) grant[ptr] = 1'b1;
    else           grant      = eligible;
  end

endmodule

// File: rtl/d_dram_arb.sv
// Arbiter sharing one single-ported data RAM between an LSU port (0) and a
// DMA port (1). Port 1 can lock the grant for bursts of up to MAX_BURST beats.
// Writes are byte-masked with a same-cycle read-modify-write; reads return
// data one cycle after accept, held until the requester takes it.
//   clk, rst_n           : clock, synchronous active-low reset
//   pN_req_*             : request channel (valid/ready, we, be, addr, wdata)
//   p1_req_lock          : port 1 wants to keep the grant for its next beat
//   pN_rsp_*             : read response channel (valid/ready, rdata)
//   ram_addr/wr_en/wr_data, ram_rd_data : RAM port, combinational read
module d_dram_arb
  import d_dram_arb_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                p0_req_valid,
  output logic                p0_req_ready,
  input  logic                p0_req_we,
  input  logic [DATA_W/8-1:0] p0_req_be,
  input  logic [ADDR_W-1:0]   p0_req_addr,
  input  logic [DATA_W-1:0]   p0_req_wdata,
  output logic                p0_rsp_valid,
  input  logic                p0_rsp_ready,
  output logic [DATA_W-1:0]   p0_rsp_rdata,
  input  logic                p1_req_valid,
  output logic                p1_req_ready,
  input  logic                p1_req_we,
  input  logic [DATA_W/8-1:0] p1_req_be,
  input  logic [ADDR_W-1:0]   p1_req_addr,
  input  logic [DATA_W-1:0]   p1_req_wdata,
  input  logic                p1_req_lock,
  output logic                p1_rsp_valid,
  input  logic                p1_rsp_ready,
  output logic [DATA_W-1:0]   p1_rsp_rdata,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_wr_en,
  output logic [DATA_W-1:0]   ram_wr_data,
  input  logic [DATA_W-1:0]   ram_rd_data
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             idle_cnt, idle_cnt_nxt;   // port-1 idle cycles seen so far in LOCK
  logic             ptr, ptr_nxt;
  logic [1:0]       eligible, elig_masked, grant, accept;
  logic             sel_we;
  logic [BE_W-1:0]  sel_be;
  logic [DATA_W-1:0] sel_wdata;

  // A port with an unconsumed response is held off until that response
  // leaves this cycle, so a new read never overwrites pending data.
  assign eligible[PORT_LSU] = p0_req_valid && (!p0_rsp_valid || p0_rsp_ready);
  assign eligible[PORT_DMA] = p1_req_valid && (!p1_rsp_valid || p1_rsp_ready);
  assign elig_masked = (state == ARB_ST_LOCK) ? {eligible[PORT_DMA], 1'b0} : eligible;

  d_dram_arb_rr u_rr (
    .eligible (elig_masked),
    .ptr      (ptr),
    .grant    (grant)
  );

  assign p0_req_ready     = rst_n && grant[PORT_LSU];
  assign p1_req_ready     = rst_n && grant[PORT_DMA];
  assign accept[PORT_LSU] = p0_req_valid && p0_req_ready;
  assign accept[PORT_DMA] = p1_req_valid && p1_req_ready;

  assign sel_we    = grant[PORT_DMA] ? p1_req_we    : p0_req_we;
  assign sel_be    = grant[PORT_DMA] ? p1_req_be    : p0_req_be;
  assign sel_wdata = grant[PORT_DMA] ? p1_req_wdata : p0_req_wdata;
  assign ram_addr  = grant[PORT_DMA] ? p1_req_addr  : p0_req_addr;
  assign ram_wr_en = (|accept) && sel_we && (|sel_be);

  // Partial writes merge with the word currently read at ram_addr so the RAM
  // only ever sees full-word writes.
  always_comb begin
    ram_wr_data = ram_rd_data;
    for (int i = 0; i < BE_W; i++) begin
      if (sel_be[i]) ram_wr_data[8*i +: 8] = sel_wdata[8*i +: 8];
    end
  end

  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    idle_cnt_nxt  = idle_cnt;
    ptr_nxt       = ptr;
    if (accept[PORT_LSU]) ptr_nxt = 1'b1;
    if (accept[PORT_DMA]) ptr_nxt = 1'b0;
    case (state)
      ARB_ST_ARB: begin
        if (accept[PORT_DMA] && p1_req_lock && (MAX_BURST > 1)) begin
          state_nxt     = ARB_ST_LOCK;
          burst_cnt_nxt = CNT_W'(1);
          idle_cnt_nxt  = 1'b0;
        end
      end
      ARB_ST_LOCK: begin
        if (accept[PORT_DMA]) begin
          burst_cnt_nxt = burst_cnt + CNT_W'(1);
          idle_cnt_nxt  = 1'b0;
          // Ending at MAX_BURST leaves ptr at port 0, so the LSU goes next.
          if (!p1_req_lock || (burst_cnt_nxt == CNT_W'(MAX_BURST))) begin
            state_nxt     = ARB_ST_ARB;
            burst_cnt_nxt = '0;
          end
        end else if (!p1_req_valid) begin
          if (idle_cnt == 1'(IDLE_LIMIT - 1)) begin
            state_nxt     = ARB_ST_ARB;
            burst_cnt_nxt = '0;
            idle_cnt_nxt  = 1'b0;
          end else begin
            idle_cnt_nxt = 1'b1;
          end
        end else begin
          idle_cnt_nxt = 1'b0;
        end
      end
      default: state_nxt = ARB_ST_ARB;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ARB_ST_ARB;
      burst_cnt    <= '0;
      idle_cnt     <= 1'b0;
      ptr          <= 1'b0;
      p0_rsp_valid <= 1'b0;
      p0_rsp_rdata <= '0;
      p1_rsp_valid <= 1'b0;
      p1_rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      idle_cnt  <= idle_cnt_nxt;
      ptr       <= ptr_nxt;
      // A new read accepted alongside a response handshake keeps valid high.
      if (accept[PORT_LSU] && !p0_req_we) begin
        p0_rsp_valid <= 1'b1;
        p0_rsp_rdata <= ram_rd_data;
      end else if (p0_rsp_ready) begin
        p0_rsp_valid <= 1'b0;
      end
      if (accept[PORT_DMA] && !p1_req_we) begin
        p1_rsp_valid <= 1'b1;
        p1_rsp_rdata <= ram_rd_data;
      end else if (p1_rsp_ready) begin
        p1_rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_d_dram_arb.sv
// Self-checking bench for d_dram_arb: directed sequences for the arbitration
// and response corner cases, a byte-merge vector table, and a randomized run
// against a behavioural model with its own shadow memory.
module tb_d_dram_arb;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 8;
  localparam int BE_W      = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid, p0_rsp_ready;
  logic [BE_W-1:0]   p0_req_be;
  logic [ADDR_W-1:0] p0_req_addr;
  logic [DATA_W-1:0] p0_req_wdata, p0_rsp_rdata;
  logic              p1_req_valid, p1_req_ready, p1_req_we, p1_req_lock, p1_rsp_valid, p1_rsp_ready;
  logic [BE_W-1:0]   p1_req_be;
  logic [ADDR_W-1:0] p1_req_addr;
  logic [DATA_W-1:0] p1_req_wdata, p1_rsp_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr_en;
  logic [DATA_W-1:0] ram_wr_data, ram_rd_data;

  // Bench-side RAM with a back-door load port used only while the DUT is idle.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [DATA_W-1:0] bd_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign ram_rd_data = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_wr_en)  mem[ram_addr] <= ram_wr_data;
    else if (bd_we) mem[bd_addr]  <= bd_data;
  end

  d_dram_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_be(p0_req_be), .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_be(p1_req_be), .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_req_lock(p1_req_lock),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
    .ram_addr(ram_addr), .ram_wr_en(ram_wr_en), .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p0_req_valid = 0; p0_req_we = 0; p0_req_be = '0; p0_req_addr = '0; p0_req_wdata = '0;
    p0_rsp_ready = 1;
    p1_req_valid = 0; p1_req_we = 0; p1_req_be = '0; p1_req_addr = '0; p1_req_wdata = '0;
    p1_req_lock = 0; p1_rsp_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic backdoor(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bd_we = 1; bd_addr = a; bd_data = d;
    step();
    bd_we = 0;
  endtask

  task automatic drive_read(input int port, input logic [ADDR_W-1:0] a, input logic lk);
    if (port == 0) begin
      p0_req_valid = 1; p0_req_we = 0; p0_req_addr = a; p0_req_be = '0;
    end else begin
      p1_req_valid = 1; p1_req_we = 0; p1_req_addr = a; p1_req_be = '0; p1_req_lock = lk;
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  typedef struct {
    logic [31:0] init;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] expect_w;
  } merge_vec_t;

  merge_vec_t vecs [5];

  // Randomized-phase model state.
  bit          m_locked;
  int          m_beats, m_idle, m_fav;
  bit          m_rv [2];
  logic [31:0] m_rd [2];
  logic [31:0] ref_mem [16];

  initial begin
    vecs[0] = '{32'h11223344, 4'b0010, 32'h0000AB00, 32'h1122AB44};
    vecs[1] = '{32'h11223344, 4'b0000, 32'hFFFFFFFF, 32'h11223344};
    vecs[2] = '{32'h11223344, 4'b1111, 32'hCAFEBABE, 32'hCAFEBABE};
    vecs[3] = '{32'h11223344, 4'b1001, 32'hAABBCCDD, 32'hAA2233DD};
    vecs[4] = '{32'h00000000, 4'b0100, 32'h00550000, 32'h00550000};

    // ---- Reset: ready and write enable low with requests pending ----
    idle_inputs();
    rst_n = 0;
    p0_req_valid = 1; p0_req_we = 1; p0_req_be = 4'hF;
    p1_req_valid = 1; p1_req_we = 1; p1_req_be = 4'hF;
    @(negedge clk);
    check("rst_ready0", p0_req_ready, 0);
    check("rst_ready1", p1_req_ready, 0);
    check("rst_wr_en", ram_wr_en, 0);
    step();
    check("rst_rsp_valid0", p0_rsp_valid, 0);
    check("rst_rsp_valid1", p1_rsp_valid, 0);
    check("rst_rdata0", p0_rsp_rdata, 0);
    check("rst_rdata1", p1_rsp_rdata, 0);

    // ---- Both ports reading the same word: strict alternation ----
    do_reset();
    backdoor(12'h010, 32'hDEADBEEF);
    drive_read(0, 12'h010, 0);
    drive_read(1, 12'h010, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("alt_ready0", p0_req_ready, (i % 2 == 0));
      check("alt_ready1", p1_req_ready, (i % 2 == 1));
      if (i > 0) begin
        if ((i - 1) % 2 == 0) begin
          check("alt_rsp_valid0", p0_rsp_valid, 1);
          check("alt_rdata0", p0_rsp_rdata, 32'hDEADBEEF);
        end else begin
          check("alt_rsp_valid1", p1_rsp_valid, 1);
          check("alt_rdata1", p1_rsp_rdata, 32'hDEADBEEF);
        end
      end
      step();
    end

    // ---- Byte-enable merge table (port 0 write, then read back) ----
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      backdoor(ADDR_W'(12'h030 + i), vecs[i].init);
      p0_req_valid = 1; p0_req_we = 1; p0_req_addr = ADDR_W'(12'h030 + i);
      p0_req_be = vecs[i].be; p0_req_wdata = vecs[i].wdata;
      @(negedge clk);
      check("merge_ready0", p0_req_ready, 1);
      check("merge_wr_en", ram_wr_en, (vecs[i].be != 0));
      step();
      drive_read(0, ADDR_W'(12'h030 + i), 0);
      step();
      p0_req_valid = 0;
      @(negedge clk);
      check("merge_rsp_valid", p0_rsp_valid, 1);
      check("merge_readback", p0_rsp_rdata, vecs[i].expect_w);
      step();
    end

    // ---- Locked burst capped at MAX_BURST, LSU then served ----
    do_reset();
    drive_read(0, 12'h010, 0);
    drive_read(1, 12'h010, 1);
    begin
      int exp_g [11];
      exp_g = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
      for (int i = 0; i < 11; i++) begin
        @(negedge clk);
        check("burst_ready1", p1_req_ready, (exp_g[i] == 1));
        check("burst_ready0", p0_req_ready, (exp_g[i] == 0));
        step();
      end
    end

    // ---- Stalled LSU response: held stable, DMA still served ----
    do_reset();
    backdoor(12'h020, 32'h12345678);
    drive_read(0, 12'h020, 0);
    p0_rsp_ready = 0;
    step();
    drive_read(0, 12'h021, 0);
    drive_read(1, 12'h022, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_rsp_valid0", p0_rsp_valid, 1);
      check("stall_rdata0", p0_rsp_rdata, 32'h12345678);
      check("stall_ready0", p0_req_ready, 0);
      check("stall_ready1", p1_req_ready, 1);
      step();
    end
    p0_req_valid = 0; p1_req_valid = 0; p0_rsp_ready = 1;
    @(negedge clk);
    check("stall_hs_valid0", p0_rsp_valid, 1);
    step();
    @(negedge clk);
    check("stall_after_hs_valid0", p0_rsp_valid, 0);

    // ---- Reset in the middle of a locked burst with a pending response ----
    do_reset();
    backdoor(12'h040, 32'hCAFEF00D);
    drive_read(0, 12'h040, 0);
    p0_rsp_ready = 0;
    step();
    p0_req_valid = 0;
    drive_read(1, 12'h041, 1);
    @(negedge clk);
    check("lockrst_ready1_a", p1_req_ready, 1);
    check("lockrst_pending", p0_rsp_valid, 1);
    step();
    drive_read(0, 12'h042, 0);
    @(negedge clk);
    check("lockrst_ready1_b", p1_req_ready, 1);
    check("lockrst_ready0_b", p0_req_ready, 0);
    step();
    rst_n = 0;
    @(negedge clk);
    check("lockrst_in_rst_ready0", p0_req_ready, 0);
    check("lockrst_in_rst_ready1", p1_req_ready, 0);
    step();
    rst_n = 1;
    @(negedge clk);
    check("lockrst_rsp_dropped", p0_rsp_valid, 0);
    check("lockrst_rdata_clr", p0_rsp_rdata, 0);
    check("lockrst_ready0", p0_req_ready, 1);
    check("lockrst_ready1", p1_req_ready, 0);
    step();

    // ---- Randomized run against the behavioural model ----
    idle_inputs();
    rst_n = 0;
    step();
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = $urandom;
      backdoor(ADDR_W'(a), ref_mem[a]);
    end
    rst_n = 1;
    m_locked = 0; m_beats = 0; m_idle = 0; m_fav = 0;
    m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit          v [2], we [2], rr [2], el [2];
      bit          lk;
      logic [3:0]  be [2];
      logic [3:0]  ad [2];
      logic [31:0] wd [2];
      int          g;
      for (int n = 0; n < 2; n++) begin
        v[n]  = ($urandom_range(0, 99) < 70);
        we[n] = ($urandom_range(0, 99) < 30);
        rr[n] = ($urandom_range(0, 99) < 60);
        be[n] = 4'($urandom);
        ad[n] = 4'($urandom);
        wd[n] = $urandom;
      end
      lk = ($urandom_range(0, 99) < 80);
      p0_req_valid = v[0]; p0_req_we = we[0]; p0_req_be = be[0];
      p0_req_addr = ADDR_W'(ad[0]); p0_req_wdata = wd[0]; p0_rsp_ready = rr[0];
      p1_req_valid = v[1]; p1_req_we = we[1]; p1_req_be = be[1];
      p1_req_addr = ADDR_W'(ad[1]); p1_req_wdata = wd[1]; p1_rsp_ready = rr[1];
      p1_req_lock = lk;
      @(negedge clk);
      check("rnd_rsp_valid0", p0_rsp_valid, m_rv[0]);
      check("rnd_rsp_valid1", p1_rsp_valid, m_rv[1]);
      if (m_rv[0]) check("rnd_rdata0", p0_rsp_rdata, m_rd[0]);
      if (m_rv[1]) check("rnd_rdata1", p1_rsp_rdata, m_rd[1]);
      for (int n = 0; n < 2; n++) el[n] = v[n] && (!m_rv[n] || rr[n]);
      g = -1;
      if (m_locked)           begin if (el[1]) g = 1; end
      else if (el[0] && el[1]) g = m_fav;
      else if (el[0])          g = 0;
      else if (el[1])          g = 1;
      check("rnd_ready0", p0_req_ready, (g == 0));
      check("rnd_ready1", p1_req_ready, (g == 1));
      check("rnd_wr_en", ram_wr_en, (g >= 0) && we[g] && (be[g] != 0));
      if (g >= 0) check("rnd_ram_addr", ram_addr, ADDR_W'(ad[g]));
      // Model update for the coming clock edge.
      for (int n = 0; n < 2; n++) begin
        if (g == n && !we[n]) begin
          m_rv[n] = 1;
          m_rd[n] = ref_mem[ad[n]];
        end else if (m_rv[n] && rr[n]) begin
          m_rv[n] = 0;
        end
      end
      if (g >= 0 && we[g]) ref_mem[ad[g]] = merge(ref_mem[ad[g]], wd[g], be[g]);
      if (g >= 0) m_fav = 1 - g;
      if (!m_locked) begin
        if (g == 1 && lk) begin
          m_locked = 1; m_beats = 1; m_idle = 0;
        end
      end else if (g == 1) begin
        m_beats++;
        m_idle = 0;
        if (!lk || m_beats == MAX_BURST) m_locked = 0;
      end else if (!v[1]) begin
        m_idle++;
        if (m_idle == 2) m_locked = 0;
      end else begin
        m_idle = 0;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/d_dram_arb.md
D_DRAM_ARB -- requirements
Module: d_dram_arb

Interface
REQ-001 ADDR_W, default 12, RAM word-address width.
REQ-002 DATA_W, default 32, word width; byte enables are DATA_W/8 wide.
REQ-003 MAX_BURST, default 8, maximum consecutive locked port-1 beats.
REQ-004 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 pN_req_valid  input  1  request present (N=0 LSU port, N=1 DMA port; each pN_ signal exists for both ports).
REQ-007 pN_req_ready  output  1  request accepted this cycle.
REQ-008 pN_req_we  input  1  1=write, 0=read.
REQ-009 pN_req_be  input  DATA_W/8  write byte enables.
REQ-010 pN_req_addr  input  ADDR_W  word address.
REQ-011 pN_req_wdata  input  DATA_W  write data.
REQ-012 p1_req_lock  input  1  port 1 requests the grant for its next beat.
REQ-013 pN_rsp_valid  output  1  read data valid.
REQ-014 pN_rsp_ready  input  1  requester consumes read data.
REQ-015 pN_rsp_rdata  output  DATA_W  read data.
REQ-016 ram_addr  output  ADDR_W  to data RAM address.
REQ-017 ram_wr_en  output  1  to data RAM write enable.
REQ-018 ram_wr_data  output  DATA_W  to data RAM write data.
REQ-019 ram_rd_data  input  DATA_W  combinational read of word at ram_addr.

Function
REQ-020 Accept = pN_req_valid && pN_req_ready; at most one port SHALL be ready per cycle; ready MAY depend combinationally on valid.
REQ-021 Port N eligible when pN_req_valid && (!pN_rsp_valid || pN_rsp_ready).
REQ-022 FSM states ARB, LOCK; ARB: both eligible -> grant port not granted last (round-robin pointer, updated on every accept); one eligible -> grant it.
REQ-023 ARB -> LOCK on port-1 accept with p1_req_lock=1; burst counter loads 1.
REQ-024 LOCK: only port 1 grantable; each port-1 accept increments counter.
REQ-025 LOCK -> ARB on port-1 accept with p1_req_lock=0, or when counter reaches MAX_BURST (pointer then favours port 0), or after 2 consecutive cycles with p1_req_valid=0.
REQ-026 ram_addr = granted port address; port 0 address when no grant.
REQ-027 ram_wr_en = accept && we && |be; be=0 write is accepted with no RAM write.
REQ-028 ram_wr_data byte i = be[i] ? wdata byte i : ram_rd_data byte i (same-cycle merge, single-cycle write).
REQ-029 Read: on accept, pN_rsp_rdata <= ram_rd_data, pN_rsp_valid <= 1 (latency 1); both held stable until pN_rsp_ready.
REQ-030 Response handshake and new read accept in the same cycle: rsp_valid stays 1 with the new data; otherwise rsp_valid clears on handshake.
REQ-031 Writes produce no response; addresses are not range-checked.
REQ-032 Same-address requests from both ports: serialized by arbitration; the later one sees the earlier write.

Reset
REQ-033 While rst_n=0 at a clk edge: state ARB, counter 0, pointer favours port 0, rsp_valid 0, rsp_rdata 0; ready and ram_wr_en SHALL be 0 while rst_n=0.
REQ-034 Reset mid-LOCK abandons the burst; reset with rsp_valid=1 drops the response without handshake.

Structure
REQ-035 RAM_DEPTH comes from global_config.vh; FSM encodings (ARB_ST_ARB, ARB_ST_LOCK) and port IDs go in cpu.vh.
REQ-036 One sub-module d_dram_arb_rr: 2-way round-robin picker (eligible[1:0], pointer -> one-hot grant).

Verification
REQ-037 Both ports read addr 0x010 (mem=0xDEADBEEF) every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; each rsp_rdata=0xDEADBEEF one cycle after accept.
REQ-038 Port 0 write be=4'b0010, wdata=0x0000AB00 to word 0x11223344 -> readback 0x1122AB44.
REQ-039 Port 1 lock=1 for 12 beats, port 0 valid throughout -> 8 port-1 beats, then port 0 granted, then port 1 resumes.
REQ-040 Port 0 read accepted, p0_rsp_ready=0 for 3 cycles -> rsp_valid/rdata stable, port 0 not granted; port 1 still served.
REQ-041 rst_n=0 for one cycle mid-LOCK with pending p0 response -> next cycle rsp_valid=0, state ARB, port 0 granted first.
